// File: rtl/bm_infer_initiator.sv
// AXI-Lite master for the Bayesian machine control slave: writes O1..O4 (skipping values
// already cached in the slave), then reads the result word, once per start request.
module bm_infer_initiator #(
  parameter logic [31:0] OBS_BASE       = 32'h0000_200C,
  parameter logic [31:0] RESULT_ADDR    = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         force_wr,
  input  logic [127:0] obs,
  output logic         busy,
  output logic         done,
  output logic [31:0]  result,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [31:0]  aw_addr,
  output logic         aw_valid,
  input  logic         aw_ready,
  output logic [31:0]  w_data,
  output logic [3:0]   w_strb,
  output logic         w_valid,
  input  logic         w_ready,
  input  logic [1:0]   b_resp,
  input  logic         b_valid,
  output logic         b_ready,
  output logic [31:0]  ar_addr,
  output logic         ar_valid,
  input  logic         ar_ready,
  input  logic [31:0]  r_data,
  input  logic [1:0]   r_resp,
  input  logic         r_valid,
  output logic         r_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StScan   = 3'd1;
  localparam logic [2:0] StWrReq  = 3'd2;
  localparam logic [2:0] StWrResp = 3'd3;
  localparam logic [2:0] StRdReq  = 3'd4;
  localparam logic [2:0] StRdResp = 3'd5;
  localparam logic [2:0] StFin    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0][31:0]  obs_q, obs_d;
  logic              force_q, force_d;
  logic [3:0][31:0]  cache_q, cache_d;
  logic [3:0]        cache_vld_q, cache_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [31:0]       ar_addr_q, ar_addr_d;

  logic [1:0] sel;
  logic       phase_st;

  assign sel      = idx_q[1:0];
  assign phase_st = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdResp);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    obs_d       = obs_q;
    force_d     = force_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    result_d    = result_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    ar_addr_d   = ar_addr_q;
    cnt_d       = cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          obs_d      = obs;
          force_d    = force_wr;
          busy_d     = 1'b1;
          idx_d      = 3'd0;
          err_code_d = 2'b00;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (idx_q[2]) begin
          ar_valid_d = 1'b1;
          ar_addr_d  = RESULT_ADDR;
          state_d    = StRdReq;
        end else if (force_q || !cache_vld_q[sel] || (cache_q[sel] != obs_q[sel])) begin
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_addr_d  = OBS_BASE + {27'd0, idx_q, 2'b00};
          w_data_d   = obs_q[sel];
          state_d    = StWrReq;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StWrReq: begin
        // A valid already low means its handshake completed in an earlier cycle.
        if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
        if ((!aw_valid_q || aw_ready) && (!w_valid_q || w_ready)) begin
          b_ready_d = 1'b1;
          state_d   = StWrResp;
        end
      end
      StWrResp: begin
        if (b_valid) begin
          b_ready_d = 1'b0;
          if (b_resp == 2'b00) begin
            cache_d[sel]     = obs_q[sel];
            cache_vld_d[sel] = 1'b1;
            idx_d            = idx_q + 3'd1;
            state_d          = StScan;
          end else begin
            cache_vld_d[sel] = 1'b0;
            err_code_d       = b_resp;
            err_d            = 1'b1;
            done_d           = 1'b1;
            state_d          = StFin;
          end
        end
      end
      StRdReq: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = StRdResp;
        end
      end
      StRdResp: begin
        if (r_valid) begin
          r_ready_d = 1'b0;
          if (r_resp == 2'b00) begin
            result_d = r_data;
          end else begin
            err_code_d = r_resp;
            err_d      = 1'b1;
          end
          done_d  = 1'b1;
          state_d = StFin;
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Timeout only fires when the phase made no exit this cycle.
    if (phase_st && (state_d == state_q) && (cnt_q == CNT_LAST)) begin
      aw_valid_d  = 1'b0;
      w_valid_d   = 1'b0;
      b_ready_d   = 1'b0;
      ar_valid_d  = 1'b0;
      r_ready_d   = 1'b0;
      err_code_d  = 2'b11;
      err_d       = 1'b1;
      done_d      = 1'b1;
      cache_vld_d = '0;
      state_d     = StFin;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (phase_st) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      obs_q       <= '0;
      force_q     <= 1'b0;
      cache_q     <= '0;
      cache_vld_q <= '0;
      cnt_q       <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      result_q    <= '0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      ar_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      obs_q       <= obs_d;
      force_q     <= force_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      cnt_q       <= cnt_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      result_q    <= result_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      ar_addr_q   <= ar_addr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign result   = result_q;
  assign aw_addr  = aw_addr_q;
  assign aw_valid = aw_valid_q;
  assign w_data   = w_data_q;
  assign w_strb   = 4'hF;
  assign w_valid  = w_valid_q;
  assign b_ready  = b_ready_q;
  assign ar_addr  = ar_addr_q;
  assign ar_valid = ar_valid_q;
  assign r_ready  = r_ready_q;

endmodule

// File: tb/tb_bm_infer_initiator.sv
// Bench for bm_infer_initiator: randomized AXI-Lite slave, queue scoreboard fed by a
// job-level reference model, directed scenarios for errors, timeout and reset.
module tb_bm_infer_initiator;
  localparam logic [31:0] OBS_BASE    = 32'h0000_200C;
  localparam logic [31:0] RESULT_ADDR = 32'h0000_2000;
  localparam int          TMO         = 16;

  typedef struct packed { logic rd; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct packed { logic err; logic [1:0] code; logic [31:0] res; } done_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, force_wr = 1'b0;
  logic [127:0] obs = '0;
  logic busy, done, err, aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [1:0] err_code;
  logic [31:0] result, aw_addr, w_data, ar_addr;
  logic [3:0] w_strb;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0] b_resp, r_resp;
  logic [31:0] r_data;

  bm_infer_initiator #(
    .OBS_BASE(OBS_BASE), .RESULT_ADDR(RESULT_ADDR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .force_wr(force_wr), .obs(obs),
    .busy(busy), .done(done), .result(result), .err(err), .err_code(err_code),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;
  txn_t  exp_txn[$];
  done_t exp_done[$];

  // Slave behaviour knobs
  int          max_dly = 0;
  bit          aw_after_w = 1'b0;
  int          b_fixed = -1;
  int          fail_idx = 7;
  logic [1:0]  fail_resp = 2'b10;
  logic [1:0]  rd_resp = 2'b00;
  logic [31:0] rd_data = '0;
  bit          ar_hang = 1'b0;

  // Reference model state: what the slave holds and the last good result
  logic [31:0] mcache[4];
  bit          mvld[4];
  logic [31:0] mresult = '0;
  logic [127:0] ov;
  int nw;
  bit ok;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [95:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic int dly();
    return int'($urandom_range(32'(max_dly)));
  endfunction

  function automatic int bdly();
    return (b_fixed >= 0) ? b_fixed : dly();
  endfunction

  task automatic model_job(input logic [127:0] o, input logic f, output int n, output bit good);
    txn_t t;
    done_t d;
    logic [31:0] v;
    n = 0;
    good = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = o[32*i +: 32];
      if (f || !mvld[i] || mcache[i] != v) begin
        t.rd = 1'b0; t.addr = OBS_BASE + 32'(4 * i); t.data = v;
        exp_txn.push_back(t);
        n++;
        if (i == fail_idx) begin
          mvld[i] = 1'b0;
          d.err = 1'b1; d.code = fail_resp; d.res = mresult;
          exp_done.push_back(d);
          good = 1'b0;
          return;
        end
        mcache[i] = v;
        mvld[i]   = 1'b1;
      end
    end
    if (ar_hang) begin
      for (int i = 0; i < 4; i++) mvld[i] = 1'b0;
      d.err = 1'b1; d.code = 2'b11; d.res = mresult;
      exp_done.push_back(d);
      good = 1'b0;
      return;
    end
    t.rd = 1'b1; t.addr = RESULT_ADDR; t.data = '0;
    exp_txn.push_back(t);
    if (rd_resp != 2'b00) begin
      d.err = 1'b1; d.code = rd_resp; d.res = mresult;
      good = 1'b0;
    end else begin
      mresult = rd_data;
      d.err = 1'b0; d.code = 2'b00; d.res = rd_data;
    end
    exp_done.push_back(d);
  endtask

  // Slave: drives after each rising edge; handshakes judged from what the DUT saw at the edge.
  initial begin : slave
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, widx;
    bit s_aw, s_w, s_b, s_ar, s_r;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
    ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_aw = 0; s_w = 0; s_b = 0; s_ar = 0; s_r = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
      end
      if (rst || !busy) begin
        aw_cnt = dly(); w_cnt = dly(); b_cnt = bdly(); ar_cnt = dly(); r_cnt = dly();
      end
      if (!rst) begin
        if (s_aw && aw_ready) begin aw_ready = 0; aw_cnt = dly(); end
        if (s_w && w_ready)   begin w_ready = 0;  w_cnt = dly();  end
        if (s_b && b_valid)   begin b_valid = 0;  b_cnt = bdly(); end
        if (s_ar && ar_ready) begin ar_ready = 0; ar_cnt = dly(); end
        if (s_r && r_valid)   begin r_valid = 0;  r_cnt = dly();  end
        if (aw_valid && !aw_ready) begin
          if (aw_after_w && w_valid) aw_cnt = 3;
          else if (aw_cnt == 0) aw_ready = 1;
          else aw_cnt--;
        end
        if (w_valid && !w_ready) begin
          if (w_cnt == 0) w_ready = 1; else w_cnt--;
        end
        if (b_ready && !b_valid) begin
          if (b_cnt == 0) begin
            widx    = int'((aw_addr - OBS_BASE) >> 2);
            b_valid = 1;
            b_resp  = (widx == fail_idx) ? fail_resp : 2'b00;
          end else b_cnt--;
        end
        if (ar_valid && !ar_ready && !ar_hang) begin
          if (ar_cnt == 0) ar_ready = 1; else ar_cnt--;
        end
        if (r_ready && !r_valid) begin
          if (r_cnt == 0) begin r_valid = 1; r_data = rd_data; r_resp = rd_resp; end
          else r_cnt--;
        end
      end
      s_aw = aw_valid; s_w = w_valid; s_b = b_ready; s_ar = ar_valid; s_r = r_ready;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transaction or a job.
  initial begin : monitor
    logic [31:0] cap_aw, cap_w;
    bit have_aw, have_w;
    int ar_run;
    txn_t t;
    done_t d;
    have_aw = 0; have_w = 0; ar_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_aw = 0; have_w = 0; ar_run = 0;
      end else begin
        if (aw_valid && aw_ready) begin cap_aw = aw_addr; have_aw = 1; end
        if (w_valid && w_ready) begin
          cap_w = w_data; have_w = 1;
          chk("w_strb", 96'(w_strb), 96'hF);
        end
        if (have_aw && have_w) begin
          have_aw = 0; have_w = 0;
          if (exp_txn.size() == 0) note_fail("unexpected_write", {1'b0, cap_aw, cap_w});
          else begin
            t = exp_txn.pop_front();
            chk("write", 96'({1'b0, cap_aw, cap_w}), 96'(t));
          end
        end
        if (ar_valid && ar_ready) begin
          ar_run = 0;
          if (exp_txn.size() == 0) note_fail("unexpected_read", 96'(ar_addr));
          else begin
            t = exp_txn.pop_front();
            chk("read", 96'({1'b1, ar_addr, 32'h0}), 96'(t));
          end
        end else if (ar_valid) begin
          ar_run++;
        end else if (ar_run != 0) begin
          chk("ar_valid_hold", 96'(ar_run), 96'(TMO));
          ar_run = 0;
        end
        if (done) begin
          if (exp_done.size() == 0) note_fail("unexpected_done", 96'({err, err_code, result}));
          else begin
            d = exp_done.pop_front();
            chk("done", 96'({err, err_code, result}), 96'(d));
          end
        end
      end
    end
  end

  task automatic run_job(input logic [127:0] o, input logic f, input bit extra);
    int cyc, bcnt, n;
    bit good, zw;
    zw = (max_dly == 0) && !aw_after_w && (b_fixed <= 0) && !ar_hang;
    model_job(o, f, n, good);
    @(negedge clk);
    obs = o; force_wr = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done && cyc < 400) begin
      if (busy) bcnt++;
      start = extra && (cyc == 2);
      if (extra && cyc == 2) obs = ~o;
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      note_fail("job_timeout", 96'(cyc));
    end else begin
      if (busy) bcnt++;
      if (zw && good) chk("busy_cycles", 96'(bcnt), 96'(8 + 2 * n));
      start = extra;
      @(negedge clk);
      start = 1'b0;
      chk("busy_clear", 96'(busy), 96'(0));
      if (extra) begin
        repeat (4) @(negedge clk);
        chk("no_second_job", 96'({busy, aw_valid, ar_valid}), 96'(0));
      end
    end
  endtask

  task automatic check_reset_outs();
    chk("reset_ctrl", 96'({busy, done, err, err_code, aw_valid, w_valid, b_ready, ar_valid,
                           r_ready}), 96'(0));
    chk("reset_data", 96'({result, aw_addr, w_data}), 96'(0));
    chk("reset_ar_addr", 96'(ar_addr), 96'(0));
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    for (int i = 0; i < 4; i++) begin mcache[i] = '0; mvld[i] = 1'b0; end
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 1'b0;

    rd_data = 32'hA5A5_0F0F;
    run_job(pack4(1, 2, 3, 4), 1'b0, 1'b0);
    chk("result_first", 96'(result), 96'hA5A5_0F0F);
    rd_data = 32'h1234_5678;
    run_job(pack4(1, 2, 7, 4), 1'b0, 1'b0);
    rd_data = 32'h0BAD_F00D;
    run_job(pack4(1, 2, 7, 4), 1'b1, 1'b0);
    rd_data = 32'h0000_0042;
    run_job(pack4(1, 2, 7, 4), 1'b0, 1'b0);

    // Slow slave: aw_ready trails w_ready, b_valid delayed
    aw_after_w = 1'b1; b_fixed = 5; rd_data = 32'hCAFE_0001;
    run_job(pack4(9, 8, 7, 6), 1'b0, 1'b0);
    aw_after_w = 1'b0; b_fixed = -1;

    // Write error on O2, then a retry with the same values
    fail_idx = 1; fail_resp = 2'b10;
    run_job(pack4(9, 5, 7, 6), 1'b0, 1'b0);
    chk("result_kept_wr_err", 96'(result), 96'hCAFE_0001);
    fail_idx = 7; rd_data = 32'hCAFE_0002;
    run_job(pack4(9, 5, 7, 6), 1'b0, 1'b0);

    // Read error
    rd_resp = 2'b01;
    run_job(pack4(9, 5, 7, 6), 1'b0, 1'b0);
    rd_resp = 2'b00;

    // Read address never accepted
    ar_hang = 1'b1;
    run_job(pack4(9, 5, 7, 6), 1'b0, 1'b0);
    ar_hang = 1'b0; rd_data = 32'hCAFE_0003;
    run_job(pack4(9, 5, 7, 6), 1'b0, 1'b0);

    // Reset while waiting for a write response
    b_fixed = 10;
    ov = pack4(21, 22, 23, 24);
    model_job(ov, 1'b1, nw, ok);
    @(negedge clk);
    obs = ov; force_wr = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!b_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!b_ready) note_fail("reach_wr_resp", 96'(cyc));
    rst = 1'b1;
    exp_txn.delete();
    exp_done.delete();
    for (int i = 0; i < 4; i++) mvld[i] = 1'b0;
    mresult = '0;
    @(negedge clk);
    check_reset_outs();
    rst = 1'b0;
    b_fixed = -1;
    repeat (6) @(negedge clk);
    chk("idle_after_reset", 96'(busy), 96'(0));

    // start while busy and in the done cycle
    rd_data = 32'h7777_0000;
    run_job(pack4(1, 1, 1, 1), 1'b0, 1'b1);

    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 4; i++) ov[32*i +: 32] = 32'($urandom_range(3));
      max_dly   = int'($urandom_range(3));
      fail_idx  = int'($urandom_range(11));
      fail_resp = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
      rd_resp   = ($urandom_range(7) == 0) ? 2'(1 + $urandom_range(1)) : 2'b00;
      rd_data   = $urandom;
      run_job(ov, ($urandom_range(3) == 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("txn_drained", 96'(exp_txn.size()), 96'(0));
    chk("done_drained", 96'(exp_done.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
